fir_xifu_sb_ctrl: RTL and testbench
===================================

# fir_xifu_sb_ctrl

In-order scoreboard controller for the FIR XIFU. It records every instruction the ID stage accepts and tracks commit or kill messages from the core's XIF commit interface. It gates issue back-pressure and authorises in-order retirement by the EX/WB stage. The block sits beside the ID/EX pipeline and is the only place in the XIFU that knows whether an in-flight instruction may change architectural state.

## Interface
Parameters:
- NB_SLOTS, 4, scoreboard depth; power of two, ≥2
- ID_W, 4, width of XIF instruction id

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous flush: all slots FREE, pointers 0 (err_o kept)
- issue_valid_i  in  1  ID stage accepted a valid XIFU instruction this cycle
- issue_id_i  in  ID_W  id of issued instruction
- ready_o  out  1  a slot is free; ID may issue (drives issue_ready)
- commit_valid_i  in  1  core commit message valid
- commit_id_i  in  ID_W  id being committed/killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- head_valid_o  out  1  oldest slot occupied
- head_id_o  out  ID_W  id of oldest slot
- head_committed_o  out  1  oldest slot COMMITTED
- head_killed_o  out  1  oldest slot KILLED (EX must suppress writeback/store)
- retire_valid_i  in  1  EX/WB requests retirement of oldest instruction
- retire_id_i  in  ID_W  id EX/WB is retiring
- retire_ready_o  out  1  head is COMMITTED or KILLED
- count_o  out  $clog2(NB_SLOTS+1)  occupied slots
- empty_o / full_o  out  1  count_o == 0 / == NB_SLOTS
- err_o  out  1  sticky protocol error

## Operation
- Circular buffer, head/tail pointers of $clog2(NB_SLOTS) bits, wrap naturally; slot state FREE, ISSUED, COMMITTED, KILLED plus stored id.
- Issue: issue_valid_i & ready_o writes {issue_id_i, ISSUED} at tail, tail+1. issue_valid_i while !ready_o: ignored, err_o set.
- Issue id equal to the id of any non-FREE slot: err_o set, still allocated.
- Commit: commit_valid_i searches non-FREE slots in ISSUED state for commit_id_i. On a match, the slot becomes COMMITTED, or KILLED if commit_kill_i. No match: ignored, err_o set.
- Commit bypass: commit_valid_i & issue accepted same cycle & commit_id_i == issue_id_i writes the new slot directly as COMMITTED/KILLED; no error.
- Retire: handshake retire_valid_i & retire_ready_o & retire_id_i == head_id_o frees head, head+1.
- Retire id mismatch: nothing freed, err_o set.
- retire_valid_i without retire_ready_o: no effect; EX holds request (stall).
- Killed instructions are freed only by retirement, so EX discards them in order.
- count_o next = count + issue_accepted − retire_accepted; simultaneous issue and retire keep count constant.
- clear_i has priority over issue/commit/retire in the same cycle; err_o cleared only by rst_i.

## Timing
- Reset (rst_i high, asynchronous): all slots FREE, head = tail = 0, count_o = 0.
- Reset output values: ready_o = 1, empty_o = 1, full_o = 0, head_valid_o = 0, head_id_o = 0, head_committed_o = 0, head_killed_o = 0, retire_ready_o = 0, err_o = 0.
- Reset mid-operation discards all in-flight entries immediately.
- All outputs are decoded from registered state only; there is no combinational input→output path.
- Issue → slot visible next cycle; with NB_SLOTS = 4 and empty, four back-to-back issues drop ready_o in the cycle after the 4th.
- Full + retire in the same cycle: ready_o stays 0 that cycle and rises the next; no same-cycle slot reuse.
- Commit of head → head_committed_o/retire_ready_o high next cycle. A retire in the commit cycle is not accepted.
- Throughput: one issue, one commit, one retire per cycle.

## Test plan
- Reset, then issue ids 1,2,3,4 in consecutive cycles -> count_o 4, full_o 1, ready_o 0; extra issue of id 5 -> ignored, err_o 1.
- Issue id 3, commit id 3 next cycle, retire id 3 the cycle after -> head_committed_o 1 then empty_o 1, err_o 0.
- Issue id 7 with commit_valid_i, commit_id_i 7, commit_kill_i 1 in same cycle -> next cycle head_killed_o 1, retire_ready_o 1; retire id 7 frees slot.
- Issue ids 0..3, commit 1 before 0 -> head stays id 0 with retire_ready_o 0 until id 0 commits; retire order 0,1 honoured.
- Full (ids 8–11, all committed); issue and retire id 8 in the same cycle -> issue ignored (err_o 1), count_o 3, ready_o 1 next cycle. Tail wraps to slot 0 on the next issue.
- Commit of unknown id 15 -> err_o 1, no state change.
- rst_i asserted with 3 entries in flight -> outputs immediately at reset values.

Source files
------------

// File: rtl/fir_xifu_sb_ctrl.sv
// rtl/fir_xifu_sb_ctrl.sv - in-order scoreboard tracking issue, commit/kill and retirement of XIFU instructions
module fir_xifu_sb_ctrl #(
  parameter int NB_SLOTS = 4,
  parameter int ID_W     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          issue_valid_i,
  input  logic [ID_W-1:0]               issue_id_i,
  output logic                          ready_o,
  input  logic                          commit_valid_i,
  input  logic [ID_W-1:0]               commit_id_i,
  input  logic                          commit_kill_i,
  output logic                          head_valid_o,
  output logic [ID_W-1:0]               head_id_o,
  output logic                          head_committed_o,
  output logic                          head_killed_o,
  input  logic                          retire_valid_i,
  input  logic [ID_W-1:0]               retire_id_i,
  output logic                          retire_ready_o,
  output logic [$clog2(NB_SLOTS+1)-1:0] count_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic                          err_o
);

  localparam int PTR_W = $clog2(NB_SLOTS);
  localparam int CNT_W = $clog2(NB_SLOTS+1);

  localparam logic [1:0] S_FREE      = 2'd0;
  localparam logic [1:0] S_ISSUED    = 2'd1;
  localparam logic [1:0] S_COMMITTED = 2'd2;
  localparam logic [1:0] S_KILLED    = 2'd3;

  logic [1:0]       slot_state_q [NB_SLOTS];
  logic [ID_W-1:0]  slot_id_q    [NB_SLOTS];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [1:0]       head_state;
  logic             issue_acc;
  logic             bypass;
  logic             dup_hit;
  logic             commit_hit;
  logic [PTR_W-1:0] commit_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             commit_upd;
  logic             retire_hs;
  logic             retire_acc;
  logic             err_set;

  // Outputs decoded purely from registered state; head id reads 0 when the head slot is free
  always_comb begin
    head_state       = slot_state_q[head_q];
    head_valid_o     = (head_state != S_FREE);
    head_id_o        = head_valid_o ? slot_id_q[head_q] : '0;
    head_committed_o = (head_state == S_COMMITTED);
    head_killed_o    = (head_state == S_KILLED);
    retire_ready_o   = head_committed_o | head_killed_o;
    count_o          = count_q;
    full_o           = (count_q == CNT_W'(NB_SLOTS));
    empty_o          = (count_q == '0);
    ready_o          = ~full_o;
    err_o            = err_q;
  end

  // Handshake decode, duplicate-id check and oldest-first commit search
  always_comb begin
    issue_acc  = issue_valid_i & ready_o;
    bypass     = commit_valid_i & issue_acc & (commit_id_i == issue_id_i);
    dup_hit    = 1'b0;
    commit_hit = 1'b0;
    commit_idx = '0;
    scan_idx   = '0;
    for (int i = 0; i < NB_SLOTS; i++) begin
      if (slot_state_q[i] != S_FREE && slot_id_q[i] == issue_id_i) begin
        dup_hit = 1'b1;
      end
    end
    for (int i = 0; i < NB_SLOTS; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (!commit_hit && slot_state_q[scan_idx] == S_ISSUED &&
          slot_id_q[scan_idx] == commit_id_i) begin
        commit_hit = 1'b1;
        commit_idx = scan_idx;
      end
    end
    commit_upd = commit_valid_i & ~bypass & commit_hit;
    retire_hs  = retire_valid_i & retire_ready_o;
    retire_acc = retire_hs & (retire_id_i == head_id_o);
    err_set    = (issue_valid_i & ~ready_o)
               | (issue_acc & dup_hit)
               | (commit_valid_i & ~bypass & ~commit_hit)
               | (retire_hs & (retire_id_i != head_id_o));
  end

  // Slot table, pointers, occupancy and sticky error; clear flushes everything but the error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_SLOTS; i++) begin
        slot_state_q[i] <= S_FREE;
        slot_id_q[i]    <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < NB_SLOTS; i++) begin
        slot_state_q[i] <= S_FREE;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (commit_upd) begin
        slot_state_q[commit_idx] <= commit_kill_i ? S_KILLED : S_COMMITTED;
      end
      if (issue_acc) begin
        slot_id_q[tail_q]    <= issue_id_i;
        slot_state_q[tail_q] <= bypass ? (commit_kill_i ? S_KILLED : S_COMMITTED) : S_ISSUED;
        tail_q               <= tail_q + 1'b1;
      end
      if (retire_acc) begin
        slot_state_q[head_q] <= S_FREE;
        head_q               <= head_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(issue_acc) - CNT_W'(retire_acc);
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_xifu_sb_ctrl.sv
// tb/tb_fir_xifu_sb_ctrl.sv - directed table-driven bench for the XIFU scoreboard controller
module tb_fir_xifu_sb_ctrl;

  localparam int NB_SLOTS = 4;
  localparam int ID_W     = 4;
  localparam int CNT_W    = $clog2(NB_SLOTS+1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             clear_i;
  logic             issue_valid_i;
  logic [ID_W-1:0]  issue_id_i;
  logic             ready_o;
  logic             commit_valid_i;
  logic [ID_W-1:0]  commit_id_i;
  logic             commit_kill_i;
  logic             head_valid_o;
  logic [ID_W-1:0]  head_id_o;
  logic             head_committed_o;
  logic             head_killed_o;
  logic             retire_valid_i;
  logic [ID_W-1:0]  retire_id_i;
  logic             retire_ready_o;
  logic [CNT_W-1:0] count_o;
  logic             empty_o;
  logic             full_o;
  logic             err_o;

  int n_cmp = 0;
  int n_bad = 0;

  fir_xifu_sb_ctrl #(.NB_SLOTS(NB_SLOTS), .ID_W(ID_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .issue_valid_i    (issue_valid_i),
    .issue_id_i       (issue_id_i),
    .ready_o          (ready_o),
    .commit_valid_i   (commit_valid_i),
    .commit_id_i      (commit_id_i),
    .commit_kill_i    (commit_kill_i),
    .head_valid_o     (head_valid_o),
    .head_id_o        (head_id_o),
    .head_committed_o (head_committed_o),
    .head_killed_o    (head_killed_o),
    .retire_valid_i   (retire_valid_i),
    .retire_id_i      (retire_id_i),
    .retire_ready_o   (retire_ready_o),
    .count_o          (count_o),
    .empty_o          (empty_o),
    .full_o           (full_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [3:0]  iid;
    logic        cv;
    logic [3:0]  cid;
    logic        ck;
    logic        rv;
    logic [3:0]  rid;
    logic        clr;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Expected output word {ready, hv, hid, hc, hk, rr, cnt, empty, full, err}
  function automatic logic [14:0] ex(input logic hv, input logic [3:0] hid, input logic hc,
                                     input logic hk, input logic [2:0] cnt, input logic err);
    return {cnt != 3'd4, hv, hid, hc, hk, hc | hk, cnt, cnt == 3'd0, cnt == 3'd4, err};
  endfunction

  function automatic logic [14:0] act();
    return {ready_o, head_valid_o, head_id_o, head_committed_o, head_killed_o,
            retire_ready_o, count_o, empty_o, full_o, err_o};
  endfunction

  task automatic push(input logic rst, input logic iv, input logic [3:0] iid, input logic cv,
                      input logic [3:0] cid, input logic ck, input logic rv, input logic [3:0] rid,
                      input logic clr, input logic [14:0] exp);
    vec_t r;
    r.rst = rst; r.iv = iv; r.iid = iid; r.cv = cv; r.cid = cid; r.ck = ck;
    r.rv = rv; r.rid = rid; r.clr = clr; r.exp = exp;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic iv, input logic [3:0] iid, input logic cv, input logic [3:0] cid,
                       input logic ck, input logic rv, input logic [3:0] rid, input logic clr);
    issue_valid_i  = iv;
    issue_id_i     = iid;
    commit_valid_i = cv;
    commit_id_i    = cid;
    commit_kill_i  = ck;
    retire_valid_i = rv;
    retire_id_i    = rid;
    clear_i        = clr;
  endtask

  task automatic check(input logic [14:0] exp, input string tag, input int idx);
    logic [14:0] a;
    a = act();
    n_cmp++;
    if (a !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b required %b (ready,hv,hid,hc,hk,rr,cnt,empty,full,err)",
               tag, idx, a, exp);
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic cyc(input logic iv, input logic [3:0] iid, input logic cv, input logic [3:0] cid,
                     input logic ck, input logic rv, input logic [3:0] rid);
    drive(iv, iid, cv, cid, ck, rv, rid, 1'b0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // fill to full, then overflow issue
    push(1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0));
    push(0, 1, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 1, 0));
    push(0, 1, 2, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 2, 0));
    push(0, 1, 3, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 3, 0));
    push(0, 1, 4, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 4, 0));
    push(0, 1, 5, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 0, 4, 1));
    // issue, commit (retire in commit cycle refused), retire
    push(1, 1, 3, 0, 0, 0, 0, 0, 0, ex(1, 3, 0, 0, 1, 0));
    push(0, 0, 0, 1, 3, 0, 1, 3, 0, ex(1, 3, 1, 0, 1, 0));
    push(0, 0, 0, 0, 0, 0, 1, 3, 0, ex(0, 0, 0, 0, 0, 0));
    // commit-kill bypass on issue
    push(1, 1, 7, 1, 7, 1, 0, 0, 0, ex(1, 7, 0, 1, 1, 0));
    push(0, 0, 0, 0, 0, 0, 1, 7, 0, ex(0, 0, 0, 0, 0, 0));
    // out-of-order commit, in-order retire, retire id mismatch, clear
    push(1, 1, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1, 0));
    push(0, 1, 1, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 2, 0));
    push(0, 1, 2, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 3, 0));
    push(0, 1, 3, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 4, 0));
    push(0, 0, 0, 1, 1, 0, 0, 0, 0, ex(1, 0, 0, 0, 4, 0));
    push(0, 0, 0, 0, 0, 0, 1, 0, 0, ex(1, 0, 0, 0, 4, 0));
    push(0, 0, 0, 1, 0, 0, 0, 0, 0, ex(1, 0, 1, 0, 4, 0));
    push(0, 0, 0, 0, 0, 0, 1, 0, 0, ex(1, 1, 1, 0, 3, 0));
    push(0, 0, 0, 0, 0, 0, 1, 1, 0, ex(1, 2, 0, 0, 2, 0));
    push(0, 0, 0, 1, 2, 0, 0, 0, 0, ex(1, 2, 1, 0, 2, 0));
    push(0, 0, 0, 0, 0, 0, 1, 3, 0, ex(1, 2, 1, 0, 2, 1));
    push(0, 1, 9, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 1));
    push(0, 1, 9, 0, 0, 0, 0, 0, 0, ex(1, 9, 0, 0, 1, 1));
    // duplicate id still allocated but flagged
    push(1, 1, 6, 0, 0, 0, 0, 0, 0, ex(1, 6, 0, 0, 1, 0));
    push(0, 1, 6, 0, 0, 0, 0, 0, 0, ex(1, 6, 0, 0, 2, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      drive(vecs[i].iv, vecs[i].iid, vecs[i].cv, vecs[i].cid, vecs[i].ck,
            vecs[i].rv, vecs[i].rid, vecs[i].clr);
      @(posedge clk_i);
      #1;
      check(vecs[i].exp, "vec", i);
    end

    // full + retire same cycle: issue refused, slot frees next cycle, tail wraps
    do_reset();
    for (int i = 8; i < 12; i++) cyc(1, 4'(i), 0, 0, 0, 0, 0);
    for (int i = 8; i < 12; i++) cyc(0, 0, 1, 4'(i), 0, 0, 0);
    check(ex(1, 8, 1, 0, 4, 0), "full_committed", 0);
    cyc(1, 12, 0, 0, 0, 1, 8);
    check(ex(1, 9, 1, 0, 3, 1), "full_issue_retire", 0);
    cyc(1, 12, 0, 0, 0, 0, 0);
    check(ex(1, 9, 1, 0, 4, 1), "wrap_issue", 0);
    for (int i = 9; i < 12; i++) cyc(0, 0, 0, 0, 0, 1, 4'(i));
    check(ex(1, 12, 0, 0, 1, 1), "wrap_head", 0);

    // commit of an unknown id
    do_reset();
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 15, 0, 0, 0);
    check(ex(1, 2, 0, 0, 1, 1), "unknown_commit", 0);

    // asynchronous reset with entries in flight
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 1, 1, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check(ex(1, 1, 1, 0, 3, 0), "pre_reset", 0);
    #2;
    rst_i = 1'b1;
    #1;
    check(ex(0, 0, 0, 0, 0, 0), "async_reset", 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
